// File: rtl/alu_acc_seq_pkg.sv
// Shared ALU control codes, accumulator command codes and the latched command record
// used by the accumulator sequencer.
package alu_acc_seq_pkg;

  localparam logic [2:0] ACC_LOAD       = 3'h0;
  localparam logic [2:0] ACC_CLR_STICKY = 3'h1;
  localparam logic [2:0] ALU_ADD        = 3'h2;
  localparam logic [2:0] ALU_SUB        = 3'h3;
  localparam logic [2:0] ALU_AND        = 3'h4;
  localparam logic [2:0] ALU_OR         = 3'h5;
  localparam logic [2:0] ALU_NOR        = 3'h6;
  localparam logic [2:0] ALU_XOR        = 3'h7;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] operand;
  } acc_cmd_t;

endpackage

// File: rtl/alu_acc_seq_alu32.sv
// 32-bit ALU stage: add/sub with signed overflow, bitwise logic ops, zero/negative flags.
module alu32
  import alu_acc_seq_pkg::*;
(
  output logic [31:0] out,
  output logic        overflow,
  output logic        zero,
  output logic        negative,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  control
);

  logic [31:0] sum, diff;

  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        out      = sum;
        overflow = (A[31] == B[31]) && (sum[31] != A[31]);
      end
      ALU_SUB: begin
        out      = diff;
        overflow = (A[31] != B[31]) && (diff[31] != A[31]);
      end
      ALU_AND: out = A & B;
      ALU_OR:  out = A | B;
      ALU_NOR: out = ~(A | B);
      ALU_XOR: out = A ^ B;
      default: out = '0;
    endcase
  end

  assign zero     = (out == '0);
  assign negative = out[31];

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator sequencer: accepts one command per handshake and repeats its ALU op
// against the accumulator 1..2^CNT_W-1 times, registering result and flags.
module alu_acc_seq
  import alu_acc_seq_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [31:0]       cmd_operand,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic [31:0]       acc,
  output logic              zero,
  output logic              negative,
  output logic              overflow,
  output logic              sticky_ovf,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state;
  acc_cmd_t         cmd_q;
  logic [CNT_W-1:0] rem;
  logic [31:0]      alu_out;
  logic             alu_ovf, alu_zero, alu_neg;

  // The ALU always sees the latched command; only EXEC edges commit its result.
  alu32 u_alu (
    .out      (alu_out),
    .overflow (alu_ovf),
    .zero     (alu_zero),
    .negative (alu_neg),
    .A        (acc),
    .B        (cmd_q.operand),
    .control  (cmd_q.op)
  );

  assign cmd_ready = reset && (state == S_IDLE);
  assign busy      = reset && (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      rem        <= '0;
      acc        <= '0;
      zero       <= 1'b1;
      negative   <= 1'b0;
      overflow   <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              ACC_LOAD: begin
                acc      <= cmd_operand;
                zero     <= (cmd_operand == '0);
                negative <= cmd_operand[31];
                overflow <= 1'b0;
                state    <= S_DONE;
              end
              ACC_CLR_STICKY: begin
                sticky_ovf <= 1'b0;
                state      <= S_DONE;
              end
              default: begin
                cmd_q.op      <= cmd_op;
                cmd_q.operand <= cmd_operand;
                rem           <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                state         <= S_EXEC;
              end
            endcase
          end
        end
        S_EXEC: begin
          acc        <= alu_out;
          zero       <= alu_zero;
          negative   <= alu_neg;
          overflow   <= alu_ovf;
          sticky_ovf <= sticky_ovf | alu_ovf;
          rem        <= rem - CNT_W'(1);
          if (rem == CNT_W'(1))
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
Accumulator sequencer that sits directly around the 32-bit ALU stage. It feeds the ALU its operands and control code, and consumes its out/overflow/zero/negative results. It accepts commands over a valid/ready handshake and runs each command's ALU operation 1..N times against a 32-bit accumulator. It registers the result and the flags, and keeps a sticky overflow bit for software/testbench polling.

Parameters:
CNT_W, 4, width of repeat-count field; max repeats = 2^CNT_W - 1

Ports:
clock  input  1  single system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset (sampled on posedge clock; 0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command this cycle
cmd_op  input  3  ALU control code (ADD 3'h2, SUB 3'h3, AND 3'h4, OR 3'h5, NOR 3'h6, XOR 3'h7); 3'h0 = LOAD, 3'h1 = CLR_STICKY
cmd_operand  input  32  B operand (or load value)
cmd_count  input  CNT_W  repeat count; 0 treated as 1
acc  output  32  accumulator
zero  output  1  registered ALU zero flag of last update
negative  output  1  registered ALU negative flag of last update
overflow  output  1  registered ALU overflow flag of last update
sticky_ovf  output  1  OR of every overflow since reset/CLR_STICKY
done  output  1  one-cycle pulse: command complete
busy  output  1  state != IDLE

Behaviour:
- Reset values (reset low at posedge): acc=0, zero=1, negative=0, overflow=0, sticky_ovf=0, done=0, state=IDLE. cmd_ready=0 and busy=0 while reset is low.
- Reset mid-command aborts the command: no done pulse, acc forced to 0.
- States: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1. Accept on cmd_valid && cmd_ready at the posedge.
  - ALU op: latch op, operand, and rem = (cmd_count==0 ? 1 : cmd_count); go EXEC.
  - LOAD: acc<=cmd_operand; zero<=(operand==0); negative<=operand[31]; overflow<=0; go DONE.
  - CLR_STICKY: sticky_ovf<=0; other state unchanged; go DONE.
- EXEC: cmd_ready=0.
  - ALU inputs are A=acc, B=latched operand, control=latched op.
  - Each posedge: acc<=alu out; zero/negative/overflow<=alu flags; sticky_ovf<=sticky_ovf|alu overflow; rem<=rem-1.
  - When rem==1 at the edge, go DONE.
- DONE: done=1 for exactly one cycle, cmd_ready=0; next state IDLE.
- Latency: an ALU command accepted at edge k updates acc at edges k+1..k+N. done is high in the cycle after edge k+N. The next command can be accepted at edge k+N+2. LOAD/CLR_STICKY: done in the cycle after acceptance; next accept 2 edges after.
- Handshake: cmd_* are sampled only on the accepting edge. cmd_valid held while cmd_ready=0 is ignored and not queued. Changing cmd_* during EXEC has no effect.
- Arithmetic: 32-bit two's complement wrap-around. The overflow rule is the ALU's (signed add/sub only; 0 for logic ops). Sticky overflow is never cleared by a non-overflowing op.
- The ALU may be driven with the latched values in all states. Only EXEC edges commit its results.
- Simultaneous events: reset has priority over all. CLR_STICKY overrides nothing else because it is its own command.

Decomposition:
- Shared ALU opcode defines (ALU_ADD..ALU_XOR) plus new ACC_LOAD=3'h0 and ACC_CLR_STICKY=3'h1 go in the common ALU defines include.
- FSM state encodings are local to this block.
- One sub-module: instantiate the existing alu32 (out, overflow, zero, negative, A, B, control). No second ALU copy.

Test Plan:
1. LOAD 8, then ADD operand 4 count 1 -> acc=32'hC, zero=0, overflow=0, done pulses once, busy low afterwards.
2. LOAD 3, then ADD 5 count 4 -> acc steps 8,13,18,23 on 4 consecutive edges. done is high the cycle after the 4th update. cmd_ready stays 0 throughout, and a cmd_valid held during EXEC is not accepted.
3. LOAD 32'h7fffffff, ADD 1 -> acc=32'h80000000, overflow=1, negative=1, sticky_ovf=1. Then AND 32'hffffffff -> overflow=0, sticky_ovf=1. Then CLR_STICKY -> sticky_ovf=0, acc unchanged.
4. LOAD 32'h7fffffff, SUB 32'h7fffffff -> acc=0, zero=1. Then NOR 0 -> acc=32'hffffffff, negative=1, zero=0. Then cmd_count=0 with XOR 32'h0f0f0f0f -> exactly one update, acc=32'hf0f0f0f0.
5. LOAD 0, ADD 1 count 15; drive reset low at the 3rd EXEC edge -> acc=0, zero=1, no done pulse. cmd_ready=1 in the first cycle after reset returns high, and a new LOAD 5 is accepted normally.
